// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// The optional parity stage is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

  // Expected parity bit for a data word: even parity unless odd is requested.
  function automatic logic uart_parity(input logic [63:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs that idle high.
// Both flops reset to 1, so a released reset never produces a spurious low.
module uart_sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by an external oversampling tick; LSB-first frames.
// Define UART_RX_PARITY_EN to add a parity bit, P_PARITY_ODD and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int P_DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int P_OVERSAMPLE = UART_OVERSAMPLE_DEF
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit P_PARITY_ODD = 1'b0
`endif
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   tick,
  input  logic                   rx,
  output logic [P_DATA_BITS-1:0] data,
  output logic                   valid,
  output logic                   frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   busy,
  output logic [2:0]             dbg_state
);

  // Handshake: valid and frame_err are single-cycle strobes with no back-pressure;
  // the consumer must take data in the cycle valid is high or lose it.

  localparam int TW = (P_OVERSAMPLE > 1) ? $clog2(P_OVERSAMPLE) : 1;
  localparam int BW = (P_DATA_BITS > 1) ? $clog2(P_DATA_BITS) : 1;
  localparam logic [TW-1:0] C_HALF_M1 = TW'(P_OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] C_FULL_M1 = TW'(P_OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(P_DATA_BITS - 1);

  uart_state_e            r_state;
  logic [TW-1:0]          r_tick_cnt;
  logic [BW-1:0]          r_bit_cnt;
  logic [P_DATA_BITS-1:0] r_shift;
  logic [P_DATA_BITS-1:0] r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_busy;
  logic                   w_rx_s;
  logic [TW-1:0]          w_tick_next;
  logic                   w_tick_at_end;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_bit;
  logic                   r_parity_err;
  logic                   w_par_bad;
`endif

  uart_sync2 u_sync (
    .CLK (CLK),
    .RST (RST),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  assign w_tick_next   = (r_tick_cnt == C_FULL_M1) ? '0 : r_tick_cnt + TW'(1);
  assign w_tick_at_end = tick && (r_tick_cnt == C_FULL_M1);

`ifdef UART_RX_PARITY_EN
  assign w_par_bad = r_par_bit != uart_parity(64'(r_shift), P_PARITY_ODD);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // Edge detect runs every CLK; a tick in this same cycle is ignored.
          if (!w_rx_s) begin
            r_state    <= START;
            r_busy     <= 1'b1;
            r_tick_cnt <= '0;
          end
        end

        START: begin
          if (tick) begin
            if (r_tick_cnt == C_HALF_M1) begin
              if (w_rx_s) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state    <= DATA;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
              end
            end else begin
              r_tick_cnt <= w_tick_next;
            end
          end
        end

        DATA: begin
          if (tick) begin
            r_tick_cnt <= w_tick_next;
            if (w_tick_at_end) begin
              r_shift   <= {w_rx_s, r_shift[P_DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + BW'(1);
              if (r_bit_cnt == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            r_tick_cnt <= w_tick_next;
            if (w_tick_at_end) begin
              r_par_bit <= w_rx_s;
              r_state   <= STOP;
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            r_tick_cnt <= w_tick_next;
            if (w_tick_at_end) begin
              // Leaving at mid stop bit keeps back-to-back frames aligned.
              if (w_rx_s) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (w_par_bad) begin
                  r_parity_err <= 1'b1;
                end else begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                end
`else
                r_data  <= r_shift;
                r_valid <= 1'b1;
`endif
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= WAIT_IDLE;
              end
            end
          end
        end

        WAIT_IDLE: begin
          if (w_rx_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;
  assign dbg_state = r_state;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random traffic against a frame-level model.
// Build with UART_RX_PARITY_EN defined to exercise the parity stage as well.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int W  = 8;
  localparam int OS = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         tick = 1'b0;
  logic         rx = 1'b1;
  logic [W-1:0] data;
  logic         valid;
  logic         frame_err;
  logic         busy;
  logic [2:0]   dbg_state;
`ifdef UART_RX_PARITY_EN
  logic         parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_data = '0;
  int obs_valid = 0, obs_ferr = 0, obs_perr = 0;
  int exp_valid = 0, exp_ferr = 0, exp_perr = 0;
  int tick_div = 0;

  uart_rx #(.P_DATA_BITS(W), .P_OVERSAMPLE(OS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .tick      (tick),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset / tick generation
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    tick_div = (tick_div + 1) % 4;
    tick     = (tick_div == 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: every output strobe is matched against the model
  always @(negedge CLK) begin
    if (!RST) begin
      if (valid === 1'b1) begin
        obs_valid++;
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rx_data", 32'(data), 32'(exp_q.pop_front()));
      end
      if (frame_err === 1'b1) obs_ferr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err === 1'b1) begin
        obs_perr++;
        check("perr_no_valid", 32'(valid), 32'd0);
      end
`endif
      if (valid === 1'b1 || frame_err === 1'b1)
        check("valid_ferr_excl", 32'(valid & frame_err), 32'd0);
    end
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge CLK);
      while (tick !== 1'b1) @(posedge CLK);
    end
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    wait_ticks(n * OS);
  endtask

  // Frame-level model: a good stop yields the word unless parity was corrupted.
  task automatic expect_frame(input logic [W-1:0] d, input logic stop, input logic par_flip);
    if (!stop) exp_ferr++;
    else if (par_flip) exp_perr++;
    else begin
      exp_q.push_back(d);
      exp_valid++;
      last_data = d;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic par_flip);
    expect_frame(d, stop, par_flip);
    rx = 1'b0;
    wait_ticks(OS);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_ticks(OS);
`endif
    rx = stop;
    wait_ticks(OS);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rstop;
    int           gap;

    repeat (5) @(posedge CLK);
    #1;
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    RST = 1'b0;
    idle_bits(2);

    // single good frame
    send_frame(8'h55, 1'b1, 1'b0);
    idle_bits(1);
    check("t1_data", 32'(data), 32'(last_data));
    check("t1_busy_idle", 32'(busy), 32'd0);

    // back-to-back frames with no gap
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle_bits(1);
    check("t2_data", 32'(data), 32'(last_data));

    // false start
    rx = 1'b0;
    wait_ticks(5);
    idle_bits(2);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_state", 32'(dbg_state), 32'(IDLE));
    check("t3_valid_cnt", 32'(obs_valid), 32'(exp_valid));

    // framing error then long break
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(30 * OS);
    check("t4_wait_state", 32'(dbg_state), 32'(WAIT_IDLE));
    check("t4_busy_break", 32'(busy), 32'd1);
    check("t4_data_held", 32'(data), 32'(last_data));
    check("t4_ferr_cnt", 32'(obs_ferr), 32'(exp_ferr));
    idle_bits(1);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(1);
    check("t4_data", 32'(data), 32'(last_data));

    // reset in the middle of a frame
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 5; i++) begin
      rx = 1'b1;
      wait_ticks(OS);
    end
    RST = 1'b1;
    #1;
    check("t5_data", 32'(data), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_state", 32'(dbg_state), 32'(IDLE));
    check("t5_valid", 32'(valid), 32'd0);
    last_data = '0;
    rx = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle_bits(2);
    send_frame(8'h12, 1'b1, 1'b0);
    idle_bits(1);
    check("t5_next_data", 32'(data), 32'(last_data));

`ifdef UART_RX_PARITY_EN
    // parity: wrong bit, right bit, then wrong parity with bad stop
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    check("t6_data_held", 32'(data), 32'(last_data));
    check("t6_perr_cnt", 32'(obs_perr), 32'(exp_perr));
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    check("t6_data", 32'(data), 32'(last_data));
    send_frame(8'h5A, 1'b0, 1'b1);
    idle_bits(1);
    check("t6_ferr_prio", 32'(obs_perr), 32'(exp_perr));
`endif

    // random traffic
    for (int n = 0; n < 20; n++) begin
      rd    = W'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      send_frame(rd, rstop, 1'($urandom_range(0, 4) == 0));
`else
      send_frame(rd, rstop, 1'b0);
`endif
      gap = rstop ? $urandom_range(0, 2) : 1 + $urandom_range(0, 1);
      if (gap > 0) begin
        idle_bits(gap);
        check("rnd_data", 32'(data), 32'(last_data));
      end
    end

    idle_bits(2);
    check("final_valid_cnt", 32'(obs_valid), 32'(exp_valid));
    check("final_ferr_cnt", 32'(obs_ferr), 32'(exp_ferr));
    check("final_perr_cnt", 32'(obs_perr), 32'(exp_perr));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
